// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word core requests into single-word memory
// accesses, with read-modify-write for sub-word stores and load extension.
module load_store_unit #(
  parameter int MEM_WORDS = 100,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              mem_we,
  output logic [31:0]       mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [ADDR_W-3:0] MEM_LIM = (ADDR_W-2)'(MEM_WORDS);

  state_t      state, state_nx;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q, lane_q;
  logic [31:0] idx_q, wdata_q, data_q;
  logic        accept, misalign, acc_err;
  logic [4:0]  sh;
  logic [31:0] rd_sh, ext, mask, merged;

  assign accept   = req_valid && req_ready;
  assign misalign = (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign acc_err  = misalign || (req_size == 2'b11) ||
                    (req_addr[ADDR_W-1:2] >= MEM_LIM);

  // Halfwords are 2-byte aligned, so a byte-granular shift covers both sizes.
  assign sh    = {lane_q, 3'b000};
  assign rd_sh = mem_rd >> sh;

  always_comb begin
    ext  = rd_sh;
    mask = 32'hFFFF_FFFF;
    case (size_q)
      2'b00: begin
        ext  = uns_q ? {24'h0, rd_sh[7:0]} : {{24{rd_sh[7]}}, rd_sh[7:0]};
        mask = 32'h0000_00FF << sh;
      end
      2'b01: begin
        ext  = uns_q ? {16'h0, rd_sh[15:0]} : {{16{rd_sh[15]}}, rd_sh[15:0]};
        mask = 32'h0000_FFFF << sh;
      end
      default: begin
        ext  = rd_sh;
        mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign merged = (mem_rd & ~mask) | ((wdata_q << sh) & mask);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) begin
        if (acc_err)                          state_nx = RESP;
        else if (req_we && req_size == 2'b10) state_nx = WRITE;
        else                                  state_nx = READ;
      end
      READ:    state_nx = we_q ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      idx_q   <= 32'h0;
      wdata_q <= 32'h0;
      data_q  <= 32'h0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= acc_err;
        size_q  <= req_size;
        lane_q  <= req_addr[1:0];
        idx_q   <= 32'(req_addr[ADDR_W-1:2]);
        wdata_q <= req_wdata;
        data_q  <= req_wdata;
      end else if (state == READ) begin
        data_q <= we_q ? merged : ext;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) && err_q;
  assign rsp_rdata = (state == RESP && !we_q && !err_q) ? data_q : 32'h0;
  assign mem_we    = (state == WRITE);
  assign mem_a     = idx_q;
  assign mem_wd    = (state == WRITE) ? data_q : 32'h0;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 100-word behavioural data memory.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        rsp_valid, rsp_err, busy, mem_we;
  logic [31:0] rsp_rdata, mem_a, mem_wd, mem_rd;

  logic [31:0] mem [0:99];
  int          n_chk = 0, n_fail = 0;
  int          we_cnt = 0, rsp_cnt = 0;
  int          lat;
  logic [31:0] r_data;
  logic        r_err;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(100), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .mem_we(mem_we),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = (mem_a < 32'd100) ? mem[mem_a] : 32'h0;

  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt <= we_cnt + 1;
      if (mem_a < 32'd100) mem[mem_a] <= mem_wd;
    end
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, return latency from the accept cycle plus response data.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int w;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 99; r_data = 32'hX; r_err = 1'bX;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i; r_data = rsp_rdata; r_err = rsp_err;
        break;
      end
    end
  endtask

  initial begin
    int w0, r0;
    logic [5:0] rdy_v, rsp_v;
    for (int i = 0; i < 100; i++) mem[i] = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_rsp",   32'(rsp_valid), 32'd0);
    chk("rst_memwe", 32'(mem_we), 32'd0);
    chk("rst_mema",  mem_a, 32'h0);
    chk("rst_memwd", mem_wd, 32'h0);
    rst = 1'b0;

    // word round trip
    w0 = we_cnt;
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw_lat", lat, 2);
    chk("sw_rdata", r_data, 32'h0);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    chk("sw_wecnt", we_cnt - w0, 1);
    access(1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
    chk("lw_lat", lat, 2);
    chk("lw_data", r_data, 32'hDEADBEEF);
    chk("lw_err", 32'(r_err), 32'd0);

    // byte RMW and loads
    @(negedge clk); mem[4] = 32'h11223344; w0 = we_cnt;
    access(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5);
    chk("sb_lat", lat, 3);
    chk("sb_mem", mem[4], 32'h1122A544);
    chk("sb_wecnt", we_cnt - w0, 1);
    access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    chk("lb", r_data, 32'hFFFFFFA5);
    access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    chk("lbu", r_data, 32'h000000A5);
    access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    chk("lb_lane3", r_data, 32'h00000011);

    // half RMW and loads
    access(1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001);
    chk("sh_lat", lat, 3);
    chk("sh_mem", mem[4], 32'h8001A544);
    access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    chk("lh", r_data, 32'hFFFF8001);
    access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    chk("lhu", r_data, 32'h00008001);
    access(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    chk("lh_low", r_data, 32'hFFFFA544);

    // errors: no write, zero data, T+1
    w0 = we_cnt;
    access(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    chk("lw_mis_lat", lat, 1); chk("lw_mis_err", 32'(r_err), 32'd1);
    chk("lw_mis_data", r_data, 32'h0);
    access(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF);
    chk("sh_mis_lat", lat, 1); chk("sh_mis_err", 32'(r_err), 32'd1);
    chk("sh_mis_data", r_data, 32'h0);
    access(1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678);
    chk("sz11_lat", lat, 1); chk("sz11_err", 32'(r_err), 32'd1);
    access(1'b1, 2'b10, 1'b0, 32'h190, 32'hCAFEF00D);
    chk("oor_lat", lat, 1); chk("oor_err", 32'(r_err), 32'd1);
    chk("err_wecnt", we_cnt - w0, 0);
    chk("err_mem4", mem[4], 32'h8001A544);
    // last valid word
    access(1'b1, 2'b10, 1'b0, 32'h18C, 32'hCAFEF00D);
    chk("w99_err", 32'(r_err), 32'd0);
    chk("w99_mem", mem[99], 32'hCAFEF00D);

    // handshake: valid held high across two LBs
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h10; req_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      rdy_v[c] = req_ready; rsp_v[c] = rsp_valid;
      if (c == 5) req_valid = 1'b0;
    end
    chk("hs_ready", 32'(rdy_v), 32'b001001);
    chk("hs_rsp",   32'(rsp_v), 32'b100100);

    // reset during READ of a sub-word store
    @(negedge clk); mem[4] = 32'h11223344; w0 = we_cnt; r0 = rsp_cnt;
    req_we = 1'b1; req_size = 2'b00; req_addr = 32'h11; req_wdata = 32'hA5;
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("ab_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("ab_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("ab_mem", mem[4], 32'h11223344);
    chk("ab_wecnt", we_cnt - w0, 0);
    chk("ab_rspcnt", rsp_cnt - r0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the word-only data memory.
- Converts byte, halfword and word load/store requests into word accesses. Sub-word stores use read-modify-write.
- Sign- or zero-extends load data.
- Holds the core off with a ready/busy handshake while an access is in flight, and flags misaligned, invalid-size and out-of-range accesses without touching memory.

Parameters:
- MEM_WORDS, 100: number of 32-bit words in the attached data memory. Word indices >= MEM_WORDS are out of range.
- ADDR_W, 32: width of the byte address from the core.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  core presents an access this cycle.
- req_ready  out  1  unit accepts a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 invalid.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle pulse; access complete.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid; access rejected.
- busy  out  1  state != IDLE; used by control to stall the PC.
- mem_we  out  1  data memory write enable.
- mem_a  out  32  data memory word index (req_addr >> 2).
- mem_wd  out  32  data memory write data.
- mem_rd  in  32  data memory read data; combinational from mem_a in the same cycle.

Behaviour:
- Reset: the synchronous active-high reset (rst) takes effect on the clk edge where it is high.
  - State returns to IDLE.
  - rsp_valid, rsp_err, rsp_rdata, mem_we, mem_a, mem_wd, busy all go to 0; req_ready = 1.
  - The latched request is cleared.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - Request is accepted when req_valid && req_ready; all req_* fields are latched.
  - Error check at accept: misaligned if (size 01 and addr[0]) or (size 10 and addr[1:0] != 0). Also error if size 11 or addr[ADDR_W-1:2] >= MEM_WORDS.
  - Next state: error -> RESP with err = 1. Load -> READ. Word store -> WRITE. Byte/half store -> READ.
- READ:
  - mem_a = latched word index, mem_we = 0; mem_rd is registered.
  - Load: extract the lane, extend it, go to RESP.
  - Sub-word store: merge store data into the read word, go to WRITE.
- WRITE: mem_we = 1 for exactly this one cycle, with mem_a = index and mem_wd = full or merged word. Next state RESP.
- RESP: rsp_valid = 1 for one cycle; next state IDLE. A new request can be accepted on the following cycle.
- Outside READ/WRITE: mem_we = 0 and mem_a holds the latched index. No memory write ever occurs for an error.
- Lanes (little-endian):
  - Byte lane = addr[1:0], data bits [8*lane+7 : 8*lane].
  - Half lane = addr[1], data bits [16*addr[1]+15 : 16*addr[1]].
  - Merge replaces only the addressed lane; the other bytes are preserved from mem_rd.
- Extension: byte/half is sign-extended from its MSB unless req_unsigned; word loads ignore req_unsigned.
- Latency, counted from accept cycle T (rsp_valid high in the listed cycle):
  - Error: T+1.
  - Load: T+2.
  - Word store: T+2.
  - Sub-word store: T+3.
- req_valid while busy: ignored (req_ready = 0). The core must hold the request until accepted.
- Reset mid-operation: the access is aborted with no response pulse.
  - Reset in READ: no write occurs.
  - Reset in WRITE: the write already issued that cycle stands; no response is produced.

Test Plan:
- Word round trip: SW 0xDEADBEEF @0x10, then LW @0x10 -> mem word 4 = 0xDEADBEEF, mem_we high exactly one cycle, LW rsp_rdata = 0xDEADBEEF at T+2.
- Byte RMW: word 4 preloaded 0x11223344; SB 0x000000A5 @0x11 -> word 4 = 0x1122A544 and rsp_valid at T+3. Then LB @0x11 -> 0xFFFFFFA5; LBU @0x11 -> 0x000000A5.
- Half RMW: from 0x1122A544, SH 0x8001 @0x12 -> word 0x8001A544. Then LH @0x12 -> 0xFFFF8001; LHU @0x12 -> 0x00008001.
- Errors:
  - LW @0x13 -> rsp_err = 1 at T+1.
  - SH @0x11 -> rsp_err = 1 at T+1.
  - req_size = 11 -> rsp_err = 1 at T+1.
  - SW @0x190 (index 100) -> rsp_err = 1 at T+1.
  - For all of the above: mem_we never asserted and rsp_rdata = 0.
- Handshake: req_valid held high for back-to-back LB, LB -> req_ready low for 2 cycles after each accept; second request accepted the cycle after the first rsp_valid.
- Reset abort: rst asserted during READ of SB @0x11 over 0x11223344 -> word unchanged, no rsp_valid, req_ready = 1 the cycle after reset.
